// File: rtl/risc_toy_fetch.sv
// Instruction-fetch stage: owns the PC, drives the I-memory port and buffers {instr,pc} for decode.
// Latency: issue in cycle N -> INSTR in N+1 -> ID_VALID in N+2; 1 instr/cycle sustained.
// Backpressure: ID_STALL holds ID_*; IREQ throttles once buffered + in-flight words fill the FIFO.
module risc_toy_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  output logic        o_ireq,
  output logic [29:0] o_iaddr,
  input  logic [31:0] i_instr,
  input  logic        i_br_taken,
  input  logic [31:0] i_br_target,
  input  logic        i_id_stall,
  output logic        o_id_valid,
  output logic [31:0] o_id_instr,
  output logic [31:0] o_id_pc,
  output logic [31:0] o_id_pc4
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int OW = CW + 1;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [29:0] RESET_WPC = RESET_PC[31:2];

  logic [29:0]   r_pc;
  logic [29:0]   r_req_pc;
  logic          r_inflight;
  logic [CW-1:0] r_count;
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [31:0]   r_buf_instr [FIFO_DEPTH];
  logic [29:0]   r_buf_pc    [FIFO_DEPTH];

  logic          w_pop;
  logic          w_push;
  logic [OW-1:0] w_occ;
  logic          w_unused;

  // Byte-offset bits of the redirect target carry no information for a word-aligned fetch.
  assign w_unused = ^i_br_target[1:0];

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Handshake, throttle and head-of-buffer presentation.
  always_comb begin
    o_id_valid = (r_count != '0);
    w_pop      = o_id_valid & ~i_id_stall;
    w_push     = r_inflight & ~i_br_taken;
    // Words already owned (held + returning) after this cycle's pop decide whether a new slot is free.
    w_occ      = OW'(r_count) + OW'(r_inflight) - OW'(w_pop);
    o_ireq     = ~i_rst & ~i_br_taken & (w_occ < OW'(FIFO_DEPTH));
    o_iaddr    = r_pc;
    o_id_instr = o_id_valid ? r_buf_instr[r_rptr] : '0;
    o_id_pc    = o_id_valid ? {r_buf_pc[r_rptr], 2'b00} : '0;
    o_id_pc4   = o_id_valid ? (o_id_pc + 32'd4) : '0;
  end

  // PC, in-flight tracking and FIFO bookkeeping; a redirect wipes everything and restarts at the target.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pc       <= RESET_WPC;
      r_req_pc   <= RESET_WPC;
      r_inflight <= 1'b0;
      r_count    <= '0;
      r_wptr     <= '0;
      r_rptr     <= '0;
    end else if (i_br_taken) begin
      r_pc       <= i_br_target[31:2];
      r_inflight <= 1'b0;
      r_count    <= '0;
      r_wptr     <= '0;
      r_rptr     <= '0;
    end else begin
      if (o_ireq) begin
        r_pc     <= r_pc + 30'd1;
        r_req_pc <= r_pc;
      end
      r_inflight <= o_ireq;
      if (w_push) r_wptr <= next_ptr(r_wptr);
      if (w_pop)  r_rptr <= next_ptr(r_rptr);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  // Buffer storage; contents are meaningless until counted, so no reset is needed.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_buf_instr[r_wptr] <= i_instr;
      r_buf_pc[r_wptr]    <= r_req_pc;
    end
  end

  // The issue throttle guarantees a returning word always finds a free slot.
  a_no_overflow: assert property (@(posedge i_clk) disable iff (i_rst)
    !(w_push && (r_count == CW'(FIFO_DEPTH))));

endmodule

// File: tb/tb_risc_toy_fetch.sv
// Directed bench for risc_toy_fetch with an I-memory model and an ID-side scoreboard.
// Expected PCs are queued per phase; a negedge monitor checks every word decode consumes.
// Directed per-cycle checks cover reset, throttling, redirects, PC wrap and async reset.
module tb_risc_toy_fetch;

  logic        clk = 1'b0;
  logic        i_rst;
  logic        o_ireq;
  logic [29:0] o_iaddr;
  logic [31:0] i_instr;
  logic        i_br_taken;
  logic [31:0] i_br_target;
  logic        i_id_stall;
  logic        o_id_valid;
  logic [31:0] o_id_instr;
  logic [31:0] o_id_pc;
  logic [31:0] o_id_pc4;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] exp_q [$];
  logic [31:0] mon_e;

  always #5 clk = ~clk;

  risc_toy_fetch #(.RESET_PC(32'h0000_0100), .FIFO_DEPTH(2)) dut (
    .i_clk       (clk),
    .i_rst       (i_rst),
    .o_ireq      (o_ireq),
    .o_iaddr     (o_iaddr),
    .i_instr     (i_instr),
    .i_br_taken  (i_br_taken),
    .i_br_target (i_br_target),
    .i_id_stall  (i_id_stall),
    .o_id_valid  (o_id_valid),
    .o_id_instr  (o_id_instr),
    .o_id_pc     (o_id_pc),
    .o_id_pc4    (o_id_pc4)
  );

  function automatic logic [31:0] memfn(input logic [29:0] a);
    return {a, 2'b01} ^ 32'hA5A5_0F0F;
  endfunction

  // Instruction memory: one-cycle read latency, junk when not requested.
  always @(posedge clk) i_instr <= o_ireq ? memfn(o_iaddr) : 32'hDEAD_BEEF;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  task automatic step(input logic st, input logic br, input logic [31:0] tgt);
    @(posedge clk);
    #1;
    i_id_stall  = st;
    i_br_taken  = br;
    i_br_target = tgt;
    @(negedge clk);
  endtask

  // Scoreboard monitor: every word decode actually takes must match the next expected PC.
  always @(negedge clk) begin
    if (!i_rst && o_id_valid && !i_id_stall && !i_br_taken) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL id_extra: got pc %h expected none", o_id_pc);
      end else begin
        mon_e = exp_q.pop_front();
        chk("id_pc", o_id_pc, mon_e);
        chk("id_instr", o_id_instr, memfn(mon_e[31:2]));
        chk("id_pc4", o_id_pc4, mon_e + 32'd4);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    i_rst = 1'b1; i_br_taken = 1'b0; i_br_target = '0; i_id_stall = 1'b0;
    @(negedge clk);
    chk("rst_ireq", 32'(o_ireq), 32'd0);
    chk("rst_iaddr", 32'(o_iaddr), 32'h40);
    chk("rst_valid", 32'(o_id_valid), 32'd0);
    chk("rst_instr", o_id_instr, 32'd0);
    chk("rst_pc", o_id_pc, 32'd0);
    chk("rst_pc4", o_id_pc4, 32'd0);

    // Phase 1: stream from reset, 3-cycle stall, then redirect.
    exp_q.push_back(32'h100); exp_q.push_back(32'h104); exp_q.push_back(32'h108);
    exp_q.push_back(32'h10C); exp_q.push_back(32'h110); exp_q.push_back(32'h114);
    exp_q.push_back(32'h118);
    @(posedge clk); #1 i_rst = 1'b0; @(negedge clk);                       // c0
    chk("c0_ireq", 32'(o_ireq), 32'd1);
    chk("c0_iaddr", 32'(o_iaddr), 32'h40);
    chk("c0_valid", 32'(o_id_valid), 32'd0);
    step(0, 0, 0);                                                         // c1
    chk("c1_iaddr", 32'(o_iaddr), 32'h41);
    chk("c1_valid", 32'(o_id_valid), 32'd0);
    step(0, 0, 0);                                                         // c2
    chk("c2_iaddr", 32'(o_iaddr), 32'h42);
    chk("c2_valid", 32'(o_id_valid), 32'd1);
    step(0, 0, 0); step(0, 0, 0);                                          // c3,c4
    for (int i = 5; i <= 7; i++) begin                                     // c5..c7 stalled
      step(1, 0, 0);
      chk("stall_ireq", 32'(o_ireq), 32'd0);
      chk("stall_pc", o_id_pc, 32'h10C);
      chk("stall_instr", o_id_instr, memfn(30'h43));
    end
    step(0, 0, 0);                                                         // c8
    chk("unstall_ireq", 32'(o_ireq), 32'd1);
    chk("unstall_iaddr", 32'(o_iaddr), 32'h45);
    step(0, 0, 0); step(0, 0, 0); step(0, 0, 0);                           // c9..c11
    exp_q.push_back(32'h2000); exp_q.push_back(32'h2004); exp_q.push_back(32'h2008);
    step(0, 1, 32'h2000);                                                  // c12 redirect
    chk("br_ireq", 32'(o_ireq), 32'd0);
    chk("br_stale_pc", o_id_pc, 32'h11C);
    step(0, 0, 0);                                                         // c13
    chk("br1_ireq", 32'(o_ireq), 32'd1);
    chk("br1_iaddr", 32'(o_iaddr), 32'h800);
    chk("br1_valid", 32'(o_id_valid), 32'd0);
    step(0, 0, 0);                                                         // c14
    chk("br2_valid", 32'(o_id_valid), 32'd0);
    step(0, 0, 0);                                                         // c15
    chk("br3_pc", o_id_pc, 32'h2000);
    step(0, 0, 0); step(0, 0, 0);                                          // c16,c17

    // Phase 2: fill while stalled, redirect into the top of memory, wrap.
    exp_q.push_back(32'hFFFF_FFF8); exp_q.push_back(32'hFFFF_FFFC);
    exp_q.push_back(32'h0000_0000); exp_q.push_back(32'h0000_0004);
    step(1, 0, 0);                                                         // c18
    step(1, 0, 0);                                                         // c19 full
    chk("full_ireq", 32'(o_ireq), 32'd0);
    chk("full_pc", o_id_pc, 32'h200C);
    step(1, 1, 32'hFFFF_FFFB);                                             // c20 redirect + stall
    chk("sbr_ireq", 32'(o_ireq), 32'd0);
    step(0, 0, 0);                                                         // c21
    chk("sbr1_ireq", 32'(o_ireq), 32'd1);
    chk("sbr1_iaddr", 32'(o_iaddr), 32'h3FFF_FFFE);
    chk("sbr1_valid", 32'(o_id_valid), 32'd0);
    step(0, 0, 0);                                                         // c22
    chk("sbr2_valid", 32'(o_id_valid), 32'd0);
    chk("sbr2_iaddr", 32'(o_iaddr), 32'h3FFF_FFFF);
    step(0, 0, 0);                                                         // c23
    chk("wrap_iaddr", 32'(o_iaddr), 32'h0);
    chk("sbr3_pc", o_id_pc, 32'hFFFF_FFF8);
    step(0, 0, 0);                                                         // c24
    chk("top_pc", o_id_pc, 32'hFFFF_FFFC);
    chk("top_pc4", o_id_pc4, 32'h0);
    step(0, 0, 0);                                                         // c25
    chk("wrap_pc", o_id_pc, 32'h0);
    step(0, 0, 0);                                                         // c26

    // Phase 3: asynchronous reset mid-cycle, then restart at RESET_PC.
    exp_q.push_back(32'h100); exp_q.push_back(32'h104); exp_q.push_back(32'h108);
    @(posedge clk); #3 i_rst = 1'b1; #1;
    chk("arst_ireq", 32'(o_ireq), 32'd0);
    chk("arst_valid", 32'(o_id_valid), 32'd0);
    chk("arst_iaddr", 32'(o_iaddr), 32'h40);
    @(posedge clk); @(posedge clk); #1 i_rst = 1'b0; @(negedge clk);       // c0'
    chk("re_ireq", 32'(o_ireq), 32'd1);
    chk("re_iaddr", 32'(o_iaddr), 32'h40);
    step(0, 0, 0); step(0, 0, 0); step(0, 0, 0); step(0, 0, 0);            // c1'..c4'
    step(1, 0, 0); step(1, 0, 0); step(1, 0, 0);                           // park with stall
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
